// File: rtl/ysyx_220053_mul_ctrl.sv
// Sequencer between the EXU and the iterative radix-4 Booth multiplier: operand extension,
// launch, product capture, result select and flush handling. Optional: YSYX_220053_MUL_FUSE_EN.
module ysyx_220053_mul_ctrl #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned OP_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [OP_W-1:0]       in_op,
  input  logic [XLEN-1:0]       in_src1,
  input  logic [XLEN-1:0]       in_src2,
  input  logic                  in_flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  input  logic                  m_out_valid,
  output logic [XLEN:0]         m_multiplicand,
  output logic [XLEN:0]         m_multiplier,
  input  logic [2*XLEN-1:0]     m_result,
  output logic                  busy
);

  localparam logic [OP_W-1:0] OP_MULH   = OP_W'(1);
  localparam logic [OP_W-1:0] OP_MULHSU = OP_W'(2);
  localparam logic [OP_W-1:0] OP_MULHU  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_MULW   = OP_W'(4);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  state_t            r_state, w_state_n;
  logic [OP_W-1:0]   r_op;
  logic [XLEN:0]     r_mcand, r_mplier;
  logic [XLEN-1:0]   r_out_data;
  logic              r_kill;
  logic [XLEN:0]     w_ext1, w_ext2;
  logic              w_accept, w_fuse_hit, w_done, w_drop;

  function automatic logic [XLEN-1:0] f_sel(input logic [OP_W-1:0] op,
                                            input logic [2*XLEN-1:0] p);
    logic [XLEN-1:0] r;
    case (op)
      OP_MULH, OP_MULHSU, OP_MULHU: r = p[2*XLEN-1:XLEN];
      OP_MULW:                      r = {{(XLEN-32){p[31]}}, p[31:0]};
      default:                      r = p[XLEN-1:0];
    endcase
    return r;
  endfunction

  always_comb begin
    w_ext1 = {in_src1[XLEN-1], in_src1};
    w_ext2 = {in_src2[XLEN-1], in_src2};
    case (in_op)
      OP_MULHSU: w_ext2 = {1'b0, in_src2};
      OP_MULHU: begin
        w_ext1 = {1'b0, in_src1};
        w_ext2 = {1'b0, in_src2};
      end
      OP_MULW: begin
        w_ext1 = {{(XLEN-31){in_src1[31]}}, in_src1[31:0]};
        w_ext2 = {{(XLEN-31){in_src2[31]}}, in_src2[31:0]};
      end
      default: ;
    endcase
  end

  assign in_ready       = (r_state == S_IDLE) && !in_flush;
  assign busy           = (r_state != S_IDLE);
  assign out_valid      = (r_state == S_RESP);
  assign m_valid        = (r_state == S_REQ) && !in_flush;
  assign m_multiplicand = r_mcand;
  assign m_multiplier   = r_mplier;
  assign out_data       = r_out_data;
  assign w_accept       = in_valid && in_ready;
  // A product arriving together with a flush, or after one, belongs to a killed op.
  assign w_done = (r_state == S_WAIT) && m_out_valid && !r_kill && !in_flush;
  assign w_drop = (in_flush && busy) || ((r_state == S_WAIT) && m_out_valid && r_kill);

`ifdef YSYX_220053_MUL_FUSE_EN
  logic              r_fuse_vld;
  logic [2*XLEN-1:0] r_fuse_prod;

  // Operand regs still hold the previous op's pair while IDLE, so they double as the tag.
  assign w_fuse_hit = r_fuse_vld && (w_ext1 == r_mcand) && (w_ext2 == r_mplier);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fuse_vld  <= 1'b0;
      r_fuse_prod <= '0;
    end else if (w_drop) begin
      r_fuse_vld  <= 1'b0;
    end else if (w_done) begin
      r_fuse_vld  <= 1'b1;
      r_fuse_prod <= m_result;
    end
  end
`else
  assign w_fuse_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_n = w_fuse_hit ? S_RESP : S_REQ;
      S_REQ: begin
        if (in_flush)     w_state_n = S_IDLE;
        else if (m_ready) w_state_n = S_WAIT;
      end
      S_WAIT: if (m_out_valid) w_state_n = (r_kill || in_flush) ? S_IDLE : S_RESP;
      S_RESP: if (in_flush || out_ready) w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op       <= '0;
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_out_data <= '0;
      r_kill     <= 1'b0;
    end else begin
      r_kill <= (r_state == S_WAIT) && !m_out_valid && (r_kill || in_flush);
      if (w_accept) begin
        r_op     <= in_op;
        r_mcand  <= w_ext1;
        r_mplier <= w_ext2;
`ifdef YSYX_220053_MUL_FUSE_EN
        if (w_fuse_hit) r_out_data <= f_sel(in_op, r_fuse_prod);
`endif
      end
      if (w_done) r_out_data <= f_sel(r_op, m_result);
    end
  end

endmodule

// File: tb/tb_ysyx_220053_mul_ctrl.sv
// Self-checking bench for ysyx_220053_mul_ctrl with a behavioural multiplier stand-in
// and an arithmetic reference model of the RV64M results.
module tb_ysyx_220053_mul_ctrl;
  logic          clk = 1'b0, rst = 1'b1;
  logic          in_valid = 1'b0, in_flush = 1'b0, out_ready = 1'b0;
  logic [2:0]    in_op = '0;
  logic [63:0]   in_src1 = '0, in_src2 = '0;
  logic          in_ready, out_valid, m_valid, busy;
  logic [63:0]   out_data;
  logic [64:0]   m_multiplicand, m_multiplier;
  logic          m_ready = 1'b1, m_out_valid = 1'b0;
  logic [127:0]  m_result = '0;

  int checks = 0, errors = 0;
  int cyc = 0, cnt = 0, lat_cfg = 0, launches = 0, launch_cyc = -1, pulse_cyc = -1;
  bit rdy_rand = 1'b0, force_nrdy = 1'b0;
  logic [64:0]   cap1, cap2;
  logic [127:0]  cap_prod;

  ysyx_220053_mul_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_src1(in_src1), .in_src2(in_src2), .in_flush(in_flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_out_valid(m_out_valid), .m_multiplicand(m_multiplicand), .m_multiplier(m_multiplier),
    .m_result(m_result), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  function automatic logic [63:0] ref_mul(input logic [2:0] op, input logic [63:0] a,
                                          input logic [63:0] b);
    logic signed [127:0] sa, sb;
    logic [127:0] ua, ub, p;
    logic [63:0]  lo;
    logic [31:0]  w;
    sa = $signed(a); sb = $signed(b); ua = a; ub = b;
    case (op)
      3'd1: begin p = sa * sb;          return p[127:64]; end
      3'd2: begin p = sa * $signed(ub); return p[127:64]; end
      3'd3: begin p = ua * ub;          return p[127:64]; end
      3'd4: begin w = a[31:0] * b[31:0]; return {{32{w[31]}}, w}; end
      default: begin lo = a * b;        return lo; end
    endcase
  endfunction

  // Multiplier stand-in: accepts on m_valid&&m_ready, pulses m_out_valid after a latency.
  always begin : mock
    bit hs;
    logic signed [129:0] x, y, pp;
    @(posedge clk);
    hs = m_valid && m_ready && !rst;
    if (cnt > 0 && !rst) begin
      chk("operands_stable", {m_multiplicand, m_multiplier}, {cap1, cap2});
    end
    if (hs) begin
      cap1 = m_multiplicand; cap2 = m_multiplier;
      launch_cyc = cyc; launches++;
    end
    cyc++;
    #1;
    m_out_valid = 1'b0;
    if (rst) cnt = 0;
    else if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        m_out_valid = 1'b1; m_result = cap_prod; pulse_cyc = cyc;
      end
    end
    if (hs) begin
      x = $signed(cap1); y = $signed(cap2); pp = x * y;
      cap_prod = pp[127:0];
      cnt = (lat_cfg != 0) ? lat_cfg : int'($urandom_range(1, 14));
      m_result = {$urandom, $urandom, $urandom, $urandom};
    end
    m_ready = (cnt == 0) && !force_nrdy && (!rdy_rand || ($urandom_range(0, 3) != 0));
  end

  task automatic accept_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                           output int t);
    int c;
    c = 0;
    while (!in_ready && c < 50) begin tick; c++; end
    chk("accept_ready", in_ready, 1'b1);
    in_valid = 1'b1; in_op = op; in_src1 = a; in_src2 = b; t = cyc;
    tick;
    in_valid = 1'b0; in_op = 3'($urandom);
    in_src1 = {$urandom, $urandom}; in_src2 = {$urandom, $urandom};
  endtask

  task automatic run_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                        input int hold, output logic [63:0] d);
    int t, l0;
    bit got, mv;
    logic [63:0] exp;
    exp = ref_mul(op, a, b);
    l0 = launches; got = 0; mv = 0;
    accept_op(op, a, b, t);
    for (int c = 0; c < 40; c++) begin
      if (out_valid) begin got = 1; break; end
      if (m_valid) mv = 1;
      out_ready = 1'($urandom_range(0, 1));
      tick;
    end
    out_ready = 1'b0;
    d = out_data;
    chk("out_valid_timeout", got, 1'b1);
    if (got) begin
      if (launches == l0) begin
`ifdef YSYX_220053_MUL_FUSE_EN
        chk("fuse_latency", cyc, t + 1);
        chk("fuse_no_m_valid", mv, 1'b0);
`else
        chk("launch_missing", launches - l0, 1);
`endif
      end else begin
        chk("result_latency", cyc, pulse_cyc + 1);
        if (!rdy_rand) chk("launch_latency", launch_cyc, t + 1);
      end
      chk("out_data", out_data, exp);
      repeat (hold) begin
        tick;
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_data", out_data, d);
      end
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
      chk("release_idle", {busy, out_valid}, 2'b00);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk(tag, {in_ready, out_valid, m_valid, busy}, 4'b1000);
    chk(tag, out_data, 64'h0);
    chk(tag, {m_multiplicand, m_multiplier}, 130'h0);
  endtask

  initial begin
    logic [63:0] a, b, d;
    logic [2:0]  op;
    int l1, t, c;
    bit seen;
    localparam logic [63:0] ONES = '1;

    rst = 1'b1;
    repeat (2) tick;
    chk_reset_outputs("reset_state");
    rst = 1'b0;
    tick;

    run_op(3'd0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 0, d);
    chk("vec_mul", d, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op(3'd3, ONES, ONES, 0, d);
    chk("vec_mulhu", d, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op(3'd1, ONES, ONES, 2, d);
    chk("vec_mulh", d, 64'h0);
    run_op(3'd2, ONES, ONES, 0, d);
    chk("vec_mulhsu", d, ONES);
    run_op(3'd4, 64'h7FFF_FFFF, 64'd2, 5, d);
    chk("vec_mulw", d, 64'hFFFF_FFFF_FFFF_FFFE);

    // MUL then MULH with identical operands
    a = {$urandom, $urandom}; b = {$urandom, $urandom};
    run_op(3'd0, a, b, 0, d);
    l1 = launches;
    run_op(3'd1, a, b, 0, d);
`ifdef YSYX_220053_MUL_FUSE_EN
    chk("fuse_launch_count", launches - l1, 0);
`else
    chk("fuse_launch_count", launches - l1, 1);
`endif

    // Flush in WAIT three cycles after launch
    lat_cfg = 8;
    a = {$urandom, $urandom}; b = {$urandom, $urandom};
    l1 = launches;
    accept_op(3'd0, a, b, t);
    c = 0;
    while (launches == l1 && c < 20) begin tick; c++; end
    chk("kill_launched", launches - l1, 1);
    repeat (2) tick;
    in_flush = 1'b1;
    tick;
    in_flush = 1'b0;
    c = 0; seen = 0;
    while (!m_out_valid && c < 30) begin
      if (out_valid) seen = 1;
      tick; c++;
    end
    chk("kill_pulse", m_out_valid, 1'b1);
    chk("kill_in_ready_at_pulse", in_ready, 1'b0);
    tick;
    chk("kill_in_ready_after", in_ready, 1'b1);
    chk("kill_no_out_valid", {seen, out_valid}, 2'b00);
    l1 = launches;
    run_op(3'd0, a, b, 0, d);
    chk("relaunch_after_kill", launches - l1, 1);

    // Flush in the same cycle as the product pulse
    lat_cfg = 4;
    a = {$urandom, $urandom}; b = {$urandom, $urandom};
    accept_op(3'd3, a, b, t);
    c = 0;
    while (!m_out_valid && c < 30) begin tick; c++; end
    in_flush = 1'b1;
    tick;
    in_flush = 1'b0;
    chk("coinc_dropped", {out_valid, busy}, 2'b00);
    l1 = launches;
    run_op(3'd3, a, b, 1, d);
    chk("relaunch_after_coinc", launches - l1, 1);
    lat_cfg = 0;

    // Flush in REQ, and flush while IDLE
    force_nrdy = 1'b1;
    tick;
    l1 = launches;
    accept_op(3'd2, {$urandom, $urandom}, {$urandom, $urandom}, t);
    chk("req_m_valid", m_valid, 1'b1);
    in_flush = 1'b1;
    #1;
    chk("req_flush_m_valid", {m_valid, in_ready}, 2'b00);
    tick;
    in_flush = 1'b0;
    chk("req_flush_idle", busy, 1'b0);
    chk("req_flush_no_launch", launches - l1, 0);
    force_nrdy = 1'b0;
    in_valid = 1'b1; in_flush = 1'b1;
    #1;
    chk("idle_flush_in_ready", in_ready, 1'b0);
    tick;
    in_valid = 1'b0; in_flush = 1'b0;
    chk("idle_flush_not_accepted", busy, 1'b0);

    // Flush in RESP on a repeated operand pair
    a = {$urandom, $urandom}; b = {$urandom, $urandom};
    run_op(3'd0, a, b, 0, d);
    accept_op(3'd0, a, b, t);
    c = 0;
    while (!out_valid && c < 40) begin tick; c++; end
    chk("resp_reached", out_valid, 1'b1);
    in_flush = 1'b1;
    tick;
    in_flush = 1'b0;
    chk("resp_flush_dropped", {out_valid, busy}, 2'b00);
    l1 = launches;
    run_op(3'd0, a, b, 0, d);
    chk("relaunch_after_resp_flush", launches - l1, 1);

    // Asynchronous reset in the middle of WAIT
    lat_cfg = 12;
    l1 = launches;
    accept_op(3'd1, {$urandom, $urandom}, {$urandom, $urandom}, t);
    c = 0;
    while (launches == l1 && c < 20) begin tick; c++; end
    repeat (2) tick;
    chk("pre_reset_busy", busy, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    chk_reset_outputs("async_reset");
    tick;
    rst = 1'b0;
    tick;
    chk("post_reset_idle", {busy, out_valid}, 2'b00);
    lat_cfg = 0;

    // Randomized traffic with multiplier backpressure
    rdy_rand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom);
      if ($urandom_range(0, 3) != 0 || i == 0) begin
        case ($urandom_range(0, 4))
          0: a = '1;
          1: a = 64'h8000_0000_0000_0000;
          2: a = 64'($urandom);
          default: a = {$urandom, $urandom};
        endcase
        case ($urandom_range(0, 4))
          0: b = '1;
          1: b = 64'h0000_0000_8000_0000;
          2: b = 64'($urandom);
          default: b = {$urandom, $urandom};
        endcase
      end
      run_op(op, a, b, int'($urandom_range(0, 3)), d);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation did not finish, observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end
endmodule
